lfsr_checker: RTL and testbench

- Downstream consumer of the 4-bit free-running LFSR generator. Takes the generator's 4-bit word stream and self-synchronises to it.
- Once locked, predicts each following word and flags mismatches, counting them.
- Provides the link/bit-error check for the LFSR pattern path: a SEARCH/LOCKED state machine with a flywheel predictor.

---
 rtl/lfsr_checker.sv | 78 +++++++
 tb/tb_lfsr_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 4-bit LFSR stream with flywheel prediction and error counting
module lfsr_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       data_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [3:0]       expected_o
);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state, state_d;
  logic pred_valid, pred_valid_d, err_d, hit, miss;
  logic [3:0] match_cnt, match_d, miss_cnt, miss_d, expected_d;
  logic [CNT_W-1:0] err_cnt_d;
  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[1]};
  endfunction
  assign hit  = pred_valid && data_i == expected_o && data_i != 4'd0;
  assign miss = data_i != expected_o;
  always_comb begin
    state_d      = state;
    pred_valid_d = pred_valid;
    match_d      = match_cnt;
    miss_d       = miss_cnt;
    expected_d   = expected_o;
    err_d        = 1'b0;
    if (valid_i && state == SEARCH) begin
      match_d      = hit ? match_cnt + 4'd1 : 4'd0;
      expected_d   = nxt(data_i);
      pred_valid_d = |data_i;
      if (hit && match_cnt + 4'd1 == 4'(LOCK_CNT)) begin
        state_d = LOCKED;
        match_d = 4'd0;
        miss_d  = 4'd0;
      end
    end else if (valid_i) begin
      // flywheel: prediction advances on its own, data never reseeds it
      expected_d = nxt(expected_o);
      miss_d     = miss ? miss_cnt + 4'd1 : 4'd0;
      err_d      = miss;
      if (miss && miss_cnt + 4'd1 == 4'(UNLOCK_CNT)) begin
        state_d      = SEARCH;
        pred_valid_d = 1'b0;
        match_d      = 4'd0;
        miss_d       = 4'd0;
      end
    end
    err_cnt_d = clear_i ? {{(CNT_W-1){1'b0}}, err_d} :
                (err_d && !(&err_cnt_o)) ? err_cnt_o + 1'b1 : err_cnt_o;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      pred_valid <= 1'b0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      expected_o <= 4'd0;
      err_o      <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      state      <= state_d;
      pred_valid <= pred_valid_d;
      match_cnt  <= match_d;
      miss_cnt   <= miss_d;
      expected_o <= expected_d;
      err_o      <= err_d;
      err_cnt_o  <= err_cnt_d;
    end
  end
  assign locked_o = state == LOCKED;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed and randomized checks of lfsr_checker (8-bit and 2-bit counters) against a behavioural model
module tb_lfsr_checker;
  logic clk = 1'b0, reset_n = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [3:0] data = 4'd0;
  logic lk8, er8, lk2, er2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [3:0] ex8, ex2;
  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  int m_locked, m_pv, m_exp, m_match, m_miss, m_err, m_cnt8, m_cnt2;

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .data_i(data), .valid_i(valid), .clear_i(clear),
    .locked_o(lk8), .err_o(er8), .err_cnt_o(cnt8), .expected_o(ex8));
  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .data_i(data), .valid_i(valid), .clear_i(clear),
    .locked_o(lk2), .err_o(er2), .err_cnt_o(cnt2), .expected_o(ex2));

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int nx(int s);
    return ((s * 2) & 14) | (((s >> 3) ^ (s >> 1)) & 1);
  endfunction

  task automatic model_reset();
    m_locked = 0; m_pv = 0; m_exp = 0; m_match = 0; m_miss = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_step(bit v, int d, bit c);
    bit inc = 0;
    m_err = 0;
    if (v && !m_locked) begin
      if (m_pv && d == m_exp && d != 0) m_match++;
      else m_match = 0;
      m_exp = nx(d);
      m_pv = d != 0;
      if (m_match == 4) begin
        m_locked = 1; m_match = 0; m_miss = 0;
      end
    end else if (v) begin
      if (d == m_exp) m_miss = 0;
      else begin
        inc = 1; m_err = 1; m_miss++;
        if (m_miss == 3) begin
          m_locked = 0; m_pv = 0; m_match = 0; m_miss = 0;
        end
      end
      m_exp = nx(m_exp);
    end
    if (c) begin
      m_cnt8 = inc; m_cnt2 = inc;
    end else if (inc) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
  endtask

  task automatic cyc(bit v, int d, bit c);
    valid = v; data = d[3:0]; clear = c;
    @(posedge clk);
    model_step(v, d & 15, c);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("locked8", lk8, m_locked);
    chk("err8", er8, m_err);
    chk("cnt8", cnt8, m_cnt8);
    chk("exp8", ex8, m_exp);
    chk("locked2", lk2, m_locked);
    chk("err2", er2, m_err);
    chk("cnt2", cnt2, m_cnt2);
    chk("exp2", ex2, m_exp);
  end

  initial begin
    int seq[5] = '{15, 14, 12, 9, 3};
    int pulses = 0, src = 15, lock_seen = 0, d;
    bit v, c;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_locked", lk8, 0);
    chk("rst_err", er8, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_exp", ex8, 0);
    reset_n = 1'b1;
    chk_en = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(1, seq[i], 0);
      if (i == 3) chk("cold_prelock", lk8, 0);
    end
    chk("cold_lock", lk8, 1);
    chk("cold_exp", ex8, 4'b0111);
    chk("cold_cnt", cnt8, 0);
    cyc(1, 4'b0101, 0);
    chk("single_err", er8, 1);
    chk("single_cnt", cnt8, 1);
    cyc(1, 15, 0);
    chk("single_err_gone", er8, 0);
    cyc(1, 14, 0);
    chk("single_still_locked", lk8, 1);
    chk("single_cnt_hold", cnt8, 1);
    cyc(0, 0, 1);
    chk("clear_alone", cnt8, 0);
    chk("clear_keeps_lock", lk8, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("loss_still_locked", lk8, 1);
    cyc(1, 0, 0);
    chk("loss_unlocked", lk8, 0);
    chk("loss_cnt8", cnt8, 3);
    chk("loss_cnt2", cnt2, 3);
    chk("loss_last_pulse", er8, 1);
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0);
    chk("relock", lk8, 1);
    cyc(1, 0, 0);
    chk("pre_reset_cnt", cnt8, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_locked", lk8, 0);
    chk("async_rst_cnt", cnt8, 0);
    chk("async_rst_exp", ex8, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1, seq[i], 0);
      if (i == 3) chk("gap_prelock", lk8, 0);
      if (i < 4) repeat (2) cyc(0, $urandom_range(0, 15), 0);
    end
    chk("gap_lock", lk8, 1);
    chk("gap_exp", ex8, 4'b0111);
    chk("gap_cnt", cnt8, 0);
    do_reset();
    repeat (5) cyc(1, 0, 0);
    chk("zero_no_lock", lk8, 0);
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, m_exp ^ 1, 0);
      if (er2) pulses++;
      cyc(1, m_exp, 0);
    end
    chk("sat_pulses", pulses, 5);
    chk("sat_cnt2", cnt2, 3);
    chk("sat_cnt8", cnt8, 5);
    chk("sat_locked", lk2, 1);
    cyc(1, m_exp ^ 2, 1);
    chk("clear_err_cnt8", cnt8, 1);
    chk("clear_err_cnt2", cnt2, 1);
    chk("clear_err_pulse", er8, 1);
    for (int n = 0; n < 3000; n++) begin
      v = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 19) == 0;
      d = src;
      if ($urandom_range(0, 99) < 6) d = $urandom_range(0, 15);
      if ($urandom_range(0, 199) == 0) src = $urandom_range(1, 15);
      else if (v) src = nx(src);
      cyc(v, d, c);
      if (lk8) lock_seen++;
    end
    chk("rand_lock_seen", lock_seen > 0, 1);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
